// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file write port (WE3/A3/WD3).
// Accepts LSU/ALU results (LSU priority), drops x0 writes, and exposes a pending/forward lookup.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [AW-1:0]              lsu_rd,
    input  logic [XLEN-1:0]            lsu_data,
    input  logic                       wb_stall,
    output logic                       WE3,
    output logic [AW-1:0]              A3,
    output logic [XLEN-1:0]            WD3,
    input  logic [AW-1:0]              q_a1,
    input  logic [AW-1:0]              q_a2,
    output logic                       pend1,
    output logic                       pend2,
    output logic [XLEN-1:0]            fwd1,
    output logic [XLEN-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic            not_full;
    logic            empty;
    logic            lsu_fire;
    logic            alu_fire;
    logic            push;
    logic            pop;
    logic [AW-1:0]   push_rd;
    logic [XLEN-1:0] push_data;

    // Readies look only at occupancy, never at the pop, so a full queue stays closed for one cycle.
    assign not_full  = (count < CW'(DEPTH));
    assign lsu_ready = !rst && not_full;
    assign alu_ready = !rst && not_full && !lsu_valid;

    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign push      = (lsu_fire && (lsu_rd != '0)) || (alu_fire && (alu_rd != '0));
    assign push_rd   = lsu_fire ? lsu_rd : alu_rd;
    assign push_data = lsu_fire ? lsu_data : alu_data;

    assign empty = (count == '0);
    assign WE3   = !empty && !wb_stall;
    assign A3    = empty ? '0 : rd_mem[head];
    assign WD3   = empty ? '0 : data_mem[head];
    assign pop   = WE3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + 1'b1;
            if (push)
                tail <= tail + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= push_rd;
            data_mem[tail] <= push_data;
        end
    end

    // Walk from oldest to youngest so the last hit wins as the youngest match.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        fwd1  = '0;
        fwd2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if ((q_a1 != '0) && (rd_mem[head + PW'(i)] == q_a1)) begin
                    pend1 = 1'b1;
                    fwd1  = data_mem[head + PW'(i)];
                end
                if ((q_a2 != '0) && (rd_mem[head + PW'(i)] == q_a2)) begin
                    pend2 = 1'b1;
                    fwd2  = data_mem[head + PW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios then random traffic against a queue-based model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            wb_stall = 1'b0;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic [AW-1:0]   q_a1 = '0;
    logic [AW-1:0]   q_a2 = '0;
    logic            pend1, pend2;
    logic [XLEN-1:0] fwd1, fwd2;
    logic [2:0]      count;

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .WE3(WE3), .A3(A3), .WD3(WD3),
        .q_a1(q_a1), .q_a2(q_a2), .pend1(pend1), .pend2(pend2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;
    bit   lsu_took, alu_took;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [AW-1:0] a, output logic p, output logic [XLEN-1:0] d);
        p = 1'b0;
        d = '0;
        if (a != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == a) begin
                    p = 1'b1;
                    d = mq[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic            lr, ar, we, p1, p2;
        logic [XLEN-1:0] f1, f2;
        lr = !rst && (mq.size() < DEPTH);
        ar = lr && !lsu_valid;
        we = (mq.size() != 0) && !wb_stall;
        look(q_a1, p1, f1);
        look(q_a2, p2, f2);
        chk({ph, ".count"},     64'(count),     64'(mq.size()));
        chk({ph, ".lsu_ready"}, 64'(lsu_ready), 64'(lr));
        chk({ph, ".alu_ready"}, 64'(alu_ready), 64'(ar));
        chk({ph, ".WE3"},       64'(WE3),       64'(we));
        chk({ph, ".A3"},        64'(A3),        (mq.size() != 0) ? 64'(mq[0].rd)   : 64'd0);
        chk({ph, ".WD3"},       64'(WD3),       (mq.size() != 0) ? 64'(mq[0].data) : 64'd0);
        chk({ph, ".pend1"},     64'(pend1),     64'(p1));
        chk({ph, ".fwd1"},      64'(fwd1),      64'(f1));
        chk({ph, ".pend2"},     64'(pend2),     64'(p2));
        chk({ph, ".fwd2"},      64'(fwd2),      64'(f2));
    endtask

    // Check the cycle, advance the model through the coming edge, then step one clock.
    task automatic tick(input string ph);
        bit   lr, ar, we;
        ent_t e;
        #1;
        check_all(ph);
        lr = !rst && (mq.size() < DEPTH);
        ar = lr && !lsu_valid;
        we = (mq.size() != 0) && !wb_stall;
        lsu_took = lsu_valid && lr;
        alu_took = alu_valid && ar;
        if (we)
            void'(mq.pop_front());
        if (lsu_took && lsu_rd != '0) begin
            e.rd = lsu_rd; e.data = lsu_data; mq.push_back(e);
        end else if (alu_took && alu_rd != '0) begin
            e.rd = alu_rd; e.data = alu_data; mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-up reset
        #1 rst = 1'b1;
        #1 check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();

        // Single ALU write and its one-cycle latency to WE3
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick("alu_push");
        alu_valid = 1'b0;
        #1;
        chk("alu.WE3", 64'(WE3), 64'd1);
        chk("alu.A3",  64'(A3),  64'd5);
        chk("alu.WD3", 64'(WD3), 64'hDEADBEEF);
        tick("alu_write");
        tick("alu_idle");

        // LSU priority over ALU, then in-order writes
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        #1 chk("prio.alu_ready_low", 64'(alu_ready), 64'd0);
        tick("prio_lsu");
        lsu_valid = 1'b0;
        tick("prio_alu");
        alu_valid = 1'b0;
        #1 chk("prio.A3_second", 64'(A3), 64'd4);
        tick("prio_w4");
        tick("prio_idle");

        // Fill under stall, hold an offer while full, drain, refill across wrap
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            lsu_valid = 1'b1; lsu_rd = AW'(i); lsu_data = 32'h100 + i;
            tick("fill");
        end
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h999;
        #1 chk("full.count", 64'(count), 64'd4);
        tick("full_stalled");
        wb_stall = 1'b0;
        tick("full_pop_no_push");
        tick("full_slot_reopens");
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("drain");
        wb_stall = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            lsu_valid = 1'b1; lsu_rd = AW'(i); lsu_data = 32'h200 + i;
            tick("wrap_fill");
        end
        lsu_valid = 1'b0;
        wb_stall = 1'b0;
        for (int i = 0; i < 5; i++) tick("wrap_drain");

        // x0 writes handshake but are never queued
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        tick("x0_push");
        alu_valid = 1'b0;
        tick("x0_after");

        // Forwarding picks the youngest matching entry
        wb_stall = 1'b1;
        q_a1 = 5'd7; q_a2 = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA;
        tick("fwd_a");
        lsu_data = 32'hB;
        tick("fwd_b");
        lsu_valid = 1'b0;
        #1 chk("fwd.fwd1_youngest", 64'(fwd1), 64'hB);
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
        tick("fwd_c");
        alu_valid = 1'b0;

        // Asynchronous reset mid-cycle with three entries held
        #2 rst = 1'b1;
        #1;
        chk("areset.count", 64'(count), 64'd0);
        chk("areset.WE3",   64'(WE3),   64'd0);
        chk("areset.pend1", 64'(pend1), 64'd0);
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wb_stall = 1'b0;
        #1 chk("areset.lsu_ready", 64'(lsu_ready), 64'd1);
        tick("post_reset");

        // Random traffic, producers hold their offer until accepted
        for (int n = 0; n < 600; n++) begin
            if (!lsu_valid || lsu_took) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = AW'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            if (!alu_valid || alu_took) begin
                alu_valid = ($urandom_range(0, 1) == 0);
                alu_rd    = AW'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            wb_stall = ($urandom_range(0, 9) < 4);
            q_a1 = AW'($urandom_range(0, 7));
            q_a2 = AW'($urandom_range(0, 7));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
